// File: rtl/npu_acc_pkg.sv
// npu_acc_pkg: shared state encoding, default widths and signed range helpers for the psum accumulator
package npu_acc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam int PSUM_W_DEF = 19;
  localparam int ACC_W_DEF = 32;
  localparam int CNT_W_DEF = 8;
  function automatic logic [63:0] acc_smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] acc_smin(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/npu_acc_sat_add.sv
// npu_acc_sat_add: ACC_W add of a sign-extended psum; clamps and flags overflow when NPU_ACC_SAT_EN is defined
module npu_acc_sat_add import npu_acc_pkg::*; #(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PSUM_W-1:0] psum,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] raw;
`ifdef NPU_ACC_SAT_EN
  localparam logic [ACC_W-1:0] SMAX = ACC_W'(acc_smax(ACC_W));
  localparam logic [ACC_W-1:0] SMIN = ACC_W'(acc_smin(ACC_W));
`endif
  always_comb begin
    ext = ACC_W'($signed(psum));
    raw = acc + ext;
`ifdef NPU_ACC_SAT_EN
    ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
    sum = ovf ? (acc[ACC_W-1] ? SMIN : SMAX) : raw;
`else
    ovf = 1'b0;
    sum = raw;
`endif
  end
endmodule

// File: rtl/npu_psum_accumulator.sv
// npu_psum_accumulator: sums cfg_len add-tree psums into one result on valid/ready; NPU_ACC_SAT_EN selects saturating adds
module npu_psum_accumulator import npu_acc_pkg::*; #(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              psum_valid,
  input  logic [PSUM_W-1:0] psum_data,
  output logic              psum_ready,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc_data,
  input  logic              acc_ready,
  output logic              busy,
  output logic              sat_flag
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic             sat_q, sat_d, ovf, take, done, launch, last;
  npu_acc_sat_add #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) u_add (
    .acc(acc_q), .psum(psum_data), .sum(sum), .ovf(ovf)
  );
  assign psum_ready = state_q == ACCUM;
  assign acc_valid = state_q == HOLD;
  assign busy = state_q != IDLE;
  assign acc_data = acc_q;
  assign sat_flag = sat_q;
  always_comb begin
    take = psum_valid && psum_ready;
    done = acc_valid && acc_ready;
    launch = start && (state_q == IDLE || done);
    last = take && cnt_q == len_q - 1'b1;
    state_d = launch ? ACCUM : last ? HOLD : done ? IDLE : state_q;
    len_d = launch ? (cfg_len == '0 ? CNT_W'(1) : cfg_len) : len_q;
    cnt_d = launch ? '0 : take ? cnt_q + 1'b1 : cnt_q;
    acc_d = launch ? '0 : take ? sum : acc_q;
    sat_d = launch ? 1'b0 : sat_q | (take & ovf);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      len_q <= '0;
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end
endmodule

// File: tb/tb_npu_psum_accumulator.sv
// tb_npu_psum_accumulator: random and directed jobs on a 32-bit and a 20-bit accumulator against a sum-of-list model
module tb_npu_psum_accumulator;
  logic clk = 1'b0;
  logic rst_n, start, psum_valid, acc_ready;
  logic [7:0] cfg_len;
  logic [18:0] psum_data;
  logic rdy_a, vld_a, busy_a, sat_a, rdy_b, vld_b, busy_b, sat_b;
  logic [31:0] acc_a;
  logic [19:0] acc_b;
  int checks = 0, failures = 0;
  int q[$];
  logic [63:0] e32, e20;
  bit s32, s20;
  always #5 clk = ~clk;
  npu_psum_accumulator dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .psum_valid(psum_valid),
    .psum_data(psum_data), .psum_ready(rdy_a), .acc_valid(vld_a), .acc_data(acc_a),
    .acc_ready(acc_ready), .busy(busy_a), .sat_flag(sat_a)
  );
  npu_psum_accumulator #(.ACC_W(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .psum_valid(psum_valid),
    .psum_data(psum_data), .psum_ready(rdy_b), .acc_valid(vld_b), .acc_data(acc_b),
    .acc_ready(acc_ready), .busy(busy_b), .sat_flag(sat_b)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic longint model(input int w, output bit sat);
    longint a = 0;
`ifdef NPU_ACC_SAT_EN
    longint mx = (longint'(1) << (w - 1)) - 1;
    longint mn = -mx - 1;
`endif
    sat = 1'b0;
    foreach (q[i]) begin
      a += q[i];
`ifdef NPU_ACC_SAT_EN
      if (a > mx) begin a = mx; sat = 1'b1; end
      else if (a < mn) begin a = mn; sat = 1'b1; end
`endif
    end
    return a;
  endfunction
  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(busy_a), 64'd0);
    check({tag, "_rdy"}, 64'(rdy_a), 64'd0);
    check({tag, "_vld"}, 64'(vld_a), 64'd0);
    check({tag, "_busy20"}, 64'(busy_b), 64'd0);
  endtask
  task automatic check_hold(input string tag);
    check({tag, "_vld"}, 64'(vld_a), 64'd1);
    check({tag, "_rdy"}, 64'(rdy_a), 64'd0);
    check({tag, "_acc"}, 64'(acc_a), e32);
    check({tag, "_sat"}, 64'(sat_a), 64'(s32));
    check({tag, "_vld20"}, 64'(vld_b), 64'd1);
    check({tag, "_acc20"}, 64'(acc_b), e20);
    check({tag, "_sat20"}, 64'(sat_b), 64'(s20));
  endtask
  task automatic start_job(input int len);
    start = 1'b1;
    cfg_len = 8'(len);
    step();
    start = 1'b0;
    check("start_rdy", 64'(rdy_a), 64'd1);
    check("start_busy", 64'(busy_a), 64'd1);
  endtask
  task automatic feed(input string tag, input bit gaps);
    longint r;
    foreach (q[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        psum_valid = 1'b0;
        step();
      end
      check({tag, "_beat_rdy"}, 64'(rdy_a), 64'd1);
      check({tag, "_beat_vld"}, 64'(vld_b), 64'd0);
      psum_valid = 1'b1;
      psum_data = 19'(q[i]);
      step();
    end
    psum_valid = 1'b0;
    r = model(32, s32);
    e32 = 64'(r) & 64'hFFFF_FFFF;
    r = model(20, s20);
    e20 = 64'(r) & 64'hF_FFFF;
    check_hold(tag);
  endtask
  task automatic finish(input string tag, input int hold, input bit restart, input int len);
    acc_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      psum_valid = 1'($urandom_range(0, 1));
      psum_data = 19'($urandom);
      step();
      check_hold({tag, "_wait"});
    end
    psum_valid = 1'b0;
    acc_ready = 1'b1;
    start = restart;
    cfg_len = 8'(len);
    step();
    acc_ready = 1'b0;
    start = 1'b0;
    check({tag, "_hs_vld"}, 64'(vld_a), 64'd0);
    check({tag, "_hs_busy"}, 64'(busy_a), 64'(restart));
    check({tag, "_hs_rdy"}, 64'(rdy_b), 64'(restart));
  endtask
  initial begin
    int len, nlen;
    bit chained;
    rst_n = 1'b0;
    start = 1'b0;
    cfg_len = '0;
    psum_valid = 1'b0;
    psum_data = '0;
    acc_ready = 1'b0;
    repeat (2) step();
    check("rst_acc", 64'(acc_a), 64'd0);
    check("rst_sat", 64'(sat_a), 64'd0);
    check_idle("rst");
    rst_n = 1'b1;
    psum_valid = 1'b1;
    psum_data = 19'd55;
    repeat (3) step();
    psum_valid = 1'b0;
    check_idle("idle_ignore");
    check("idle_acc", 64'(acc_a), 64'd0);
    start_job(4);
    q = '{100, -200, 300, -50};
    feed("dot4", 1'b0);
    check("dot4_const", 64'(acc_a), 64'd150);
    finish("dot4", 0, 1'b0, 0);
    start_job(1);
    q = '{-262144};
    feed("len1", 1'b0);
    check("len1_const", 64'(acc_a), 64'hFFFC_0000);
    finish("len1", 0, 1'b0, 0);
    start_job(0);
    q = '{-262144};
    feed("len0", 1'b0);
    finish("len0", 1, 1'b0, 0);
    start_job(2);
    q = '{7, 8};
    feed("bp", 1'b0);
    finish("bp", 5, 1'b1, 3);
    q = '{1, 2, 3};
    feed("b2b", 1'b0);
    check("b2b_const", 64'(acc_a), 64'd6);
    finish("b2b", 0, 1'b0, 0);
    start_job(4);
    q = '{262143, 262143, 262143, 262143};
    feed("satp", 1'b0);
    finish("satp", 0, 1'b1, 6);
    q = '{-262144, -262144, -262144, -262144, 262143, 5};
    feed("satn", 1'b1);
    finish("satn", 0, 1'b0, 0);
    chained = 1'b0;
    len = $urandom_range(0, 10);
    for (int j = 0; j < 24; j++) begin
      if (!chained) start_job(len);
      q.delete();
      for (int k = 0; k < (len == 0 ? 1 : len); k++) q.push_back(int'($urandom_range(0, 524287)) - 262144);
      feed("rnd", 1'b1);
      nlen = $urandom_range(0, 10);
      chained = (j < 23) && ($urandom_range(0, 1) == 1);
      finish("rnd", $urandom_range(0, 3), chained, nlen);
      len = nlen;
    end
    start_job(4);
    psum_valid = 1'b1;
    psum_data = 19'd9;
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("arst");
    check("arst_acc", 64'(acc_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    check_idle("post_rst");
    check("post_rst_acc", 64'(acc_a), 64'd0);
    psum_valid = 1'b0;
    start_job(2);
    q = '{-3, 10};
    feed("fresh", 1'b1);
    finish("fresh", 0, 1'b0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
